// File: rtl/tile_feeder_pkg.sv
// Shared types and defaults for the tile row feeder and its row buffer.
package tile_feeder_pkg;

    typedef enum logic [1:0] {LOAD, LOADED, STREAM, DRAIN} feeder_state_e;

    localparam int DEF_BIT_WIDTH  = 32;
    localparam int DEF_TRI_LENGTH = 16;
    localparam int DEF_TILE_ROWS  = 16;

    // Address width for a buffer of the given depth; never below one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tile_row_feeder_if.sv
// Row source handshake between the on-chip source (master) and the feeder (slave).
interface tile_row_feeder_if #(
    parameter int BIT_WIDTH  = tile_feeder_pkg::DEF_BIT_WIDTH,
    parameter int TRI_LENGTH = tile_feeder_pkg::DEF_TRI_LENGTH
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_last;
    logic [TRI_LENGTH*BIT_WIDTH-1:0] in_data;

    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/tile_row_buf.sv
// Tile row storage: one synchronous write port, one registered read port.
module tile_row_buf
    import tile_feeder_pkg::*;
#(
    parameter int ROW_W = DEF_TRI_LENGTH * DEF_BIT_WIDTH,
    parameter int DEPTH = DEF_TILE_ROWS,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [ROW_W-1:0] rd_data
);
    logic [ROW_W-1:0] mem [DEPTH];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // A read that is not enabled presents zeros, which covers drain and padding.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
        else            rd_data <= '0;
    end
endmodule

// File: rtl/tile_row_feeder.sv
// Loads one tile of rows, streams it one row per cycle to the skew stage, then drains.
// Optional build macro ZERO_PAD_EN pads short tiles with zero rows up to TILE_ROWS.
//
// state  | meaning
// LOAD   | accepting rows from the source, in_ready high
// LOADED | tile held, waiting for start
// STREAM | one buffered (or padding) row per cycle, all lanes enabled
// DRAIN  | TRI_LENGTH idle cycles to flush the deepest skew lane, then done
module tile_row_feeder
    import tile_feeder_pkg::*;
#(
    parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int TRI_LENGTH = DEF_TRI_LENGTH,
    parameter int TILE_ROWS  = DEF_TILE_ROWS
) (
    input  logic                            clk,
    input  logic                            rst,
    tile_row_feeder_if.slave                src,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [TRI_LENGTH-1:0]           enable_out,
    output logic [TRI_LENGTH*BIT_WIDTH-1:0] data_out
);
    localparam int ROW_W = TRI_LENGTH * BIT_WIDTH;
    localparam int AW    = addr_w(TILE_ROWS);
    localparam int CW    = $clog2(TILE_ROWS + 1);
    localparam int DW    = $clog2(TRI_LENGTH + 1);

    localparam logic [1:0] S_LOAD   = LOAD;
    localparam logic [1:0] S_LOADED = LOADED;
    localparam logic [1:0] S_STREAM = STREAM;
    localparam logic [1:0] S_DRAIN  = DRAIN;

    localparam logic [CW-1:0] ROWS_MAX   = CW'(TILE_ROWS);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(TRI_LENGTH - 1);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] wr_cnt, rd_cnt, n_rows, stream_len;
    logic [DW-1:0] drain_cnt;
    logic          accept, last_row, issue, rd_en;

    assign src.in_ready = (state == S_LOAD);
    assign accept       = src.in_valid & src.in_ready & ~rst;
    assign last_row     = src.in_last | (wr_cnt == ROWS_MAX - CW'(1));

`ifdef ZERO_PAD_EN
    assign stream_len = ROWS_MAX;
`else
    assign stream_len = n_rows;
`endif

    // rd_cnt is zero in LOADED, so the start cycle fetches row 0.
    assign issue = ((state == S_LOADED) && start) ||
                   ((state == S_STREAM) && (rd_cnt != stream_len));
    assign rd_en = issue && (rd_cnt < n_rows);

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:   if (accept && last_row)     state_nxt = S_LOADED;
            S_LOADED: if (start)                  state_nxt = S_STREAM;
            S_STREAM: if (rd_cnt == stream_len)   state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_cnt == '0)        state_nxt = S_LOAD;
            default:                              state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LOAD;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            n_rows     <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            enable_out <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt == S_STREAM) || (state_nxt == S_DRAIN);
            done       <= (state == S_DRAIN) && (drain_cnt == '0);
            enable_out <= {TRI_LENGTH{issue}};

            if (accept) begin
                if (last_row) begin
                    wr_cnt <= '0;
                    n_rows <= wr_cnt + CW'(1);
                end else begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end

            if (issue)                  rd_cnt <= rd_cnt + CW'(1);
            else if (state == S_STREAM) rd_cnt <= '0;

            if ((state == S_STREAM) && !issue)          drain_cnt <= DRAIN_LAST;
            else if ((state == S_DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - DW'(1);
        end
    end

    tile_row_buf #(
        .ROW_W (ROW_W),
        .DEPTH (TILE_ROWS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_data (src.in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt[AW-1:0]),
        .rd_data (data_out)
    );
endmodule
